// File: rtl/config_arbiter.sv
// Round-robin arbiter sharing the config_reg port between the host bridge (0) and calibration engine (1).
// Writes take IDLE->WRITE->RESP, reads IDLE->READ->CAPT->RESP; ready only in IDLE.
module config_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter logic [(1<<ADDR_W)-1:0] LOCK_MASK = 8'b0000_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              cfg_write,
  output logic [ADDR_W-1:0] cfg_address,
  output logic [DATA_W-1:0] cfg_data_in,
  input  logic [DATA_W-1:0] cfg_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPT,
    S_RESP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              winner;
  logic              err_flag;
  logic [DATA_W-1:0] wdata_q;

  logic              grant0;
  logic              grant1;
  logic              handshake;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              locked;

  // On contention the requester that was not granted last wins.
  assign grant1    = req1_valid && (!req0_valid || !last_grant);
  assign grant0    = req0_valid && !grant1;
  assign handshake = (state == S_IDLE) && (grant0 || grant1);
  assign sel_write = grant1 ? req1_write : req0_write;
  assign sel_addr  = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata = grant1 ? req1_wdata : req0_wdata;
  assign locked    = winner && LOCK_MASK[cfg_address];

  always_comb begin
    state_nxt   = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    cfg_write   = 1'b0;
    cfg_data_in = '0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    rsp0_err    = 1'b0;
    rsp1_err    = 1'b0;
    case (state)
      S_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (handshake) begin
          state_nxt = sel_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        // Combinational from the state flop so an async reset kills the strobe at once.
        cfg_write   = !locked;
        cfg_data_in = wdata_q;
        state_nxt   = S_RESP;
      end
      S_READ: begin
        state_nxt = S_CAPT;
      end
      S_CAPT: begin
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = !winner;
        rsp1_valid = winner;
        rsp0_err   = !winner && err_flag;
        rsp1_err   = winner && err_flag;
        state_nxt  = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      winner      <= 1'b0;
      err_flag    <= 1'b0;
      wdata_q     <= '0;
      cfg_address <= '0;
      rsp_rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (handshake) begin
        last_grant  <= grant1;
        winner      <= grant1;
        err_flag    <= 1'b0;
        wdata_q     <= sel_wdata;
        cfg_address <= sel_addr;
      end
      if (state == S_WRITE) begin
        err_flag  <= locked;
        rsp_rdata <= wdata_q;
      end
      if (state == S_CAPT) begin
        rsp_rdata <= cfg_data_out;
      end
    end
  end

endmodule

// File: tb/tb_config_arbiter.sv
// Randomised and directed bench for config_arbiter against a transaction-level reference model.
module tb_config_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r0v = 1'b0, r0w = 1'b0, r1v = 1'b0, r1w = 1'b0;
  logic [2:0]  r0a = '0, r1a = '0;
  logic [15:0] r0d = '0, r1d = '0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [15:0] rsp_rdata;
  logic        cfg_write;
  logic [2:0]  cfg_address;
  logic [15:0] cfg_data_in;
  logic [15:0] cfg_data_out;

  config_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(r0v), .req0_ready(req0_ready), .req0_write(r0w),
    .req0_addr(r0a), .req0_wdata(r0d),
    .req1_valid(r1v), .req1_ready(req1_ready), .req1_write(r1w),
    .req1_addr(r1a), .req1_wdata(r1d),
    .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err),
    .rsp_rdata(rsp_rdata),
    .cfg_write(cfg_write), .cfg_address(cfg_address),
    .cfg_data_in(cfg_data_in), .cfg_data_out(cfg_data_out)
  );

  always #5 clk = ~clk;

  // Stand-in for the config_reg bank: registered read port.
  logic [15:0] cr_mem [8];
  logic [15:0] cr_dout = '0;
  initial for (int i = 0; i < 8; i++) cr_mem[i] = '0;
  always @(posedge clk) begin
    if (cfg_write) cr_mem[cfg_address] <= cfg_data_in;
    cr_dout <= cr_mem[cfg_address];
  end
  assign cfg_data_out = cr_dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one transaction record plus latency arithmetic from its handshake cycle.
  logic [7:0]  lockm = 8'b0000_0001;
  logic [15:0] mref [8];
  bit          busy, lg, twho, twr, terr, hs0, hs1, w0, w1;
  int          t0, ph;
  logic [2:0]  taddr, eaddr;
  logic [15:0] twd, trd, erd;

  initial begin
    for (int i = 0; i < 8; i++) mref[i] = '0;
    busy = 0; lg = 1; eaddr = '0; erd = '0; hs0 = 0; hs1 = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (reset) begin
        chk("rst_cfg_write", cfg_write, 0);
        chk("rst_cfg_address", cfg_address, 0);
        chk("rst_cfg_data_in", cfg_data_in, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_err", rsp0_err, 0);
        chk("rst_rsp1_err", rsp1_err, 0);
        busy = 0; lg = 1; eaddr = '0; erd = '0; hs0 = 0; hs1 = 0;
      end else begin
        if (busy) begin
          ph = cyc - t0;
          if (twr ? (ph >= 3) : (ph >= 4)) busy = 0;
          if (busy && ph == 2 && twr && !terr) mref[taddr] = twd;
        end
        if (!busy) begin
          chk("idle_cfg_write", cfg_write, 0);
          chk("idle_cfg_data_in", cfg_data_in, 0);
          chk("idle_cfg_address", cfg_address, eaddr);
          chk("idle_rsp_rdata", rsp_rdata, erd);
          chk("idle_rsp0_valid", rsp0_valid, 0);
          chk("idle_rsp1_valid", rsp1_valid, 0);
          w1 = r1v && (!r0v || !lg);
          w0 = r0v && !w1;
          chk("ready0", req0_ready, w0);
          chk("ready1", req1_ready, w1);
          hs0 = w0; hs1 = w1;
          if (w0 || w1) begin
            busy  = 1; t0 = cyc; twho = w1;
            twr   = w1 ? r1w : r0w;
            taddr = w1 ? r1a : r0a;
            twd   = w1 ? r1d : r0d;
            terr  = w1 && twr && lockm[taddr];
            trd   = twr ? twd : mref[taddr];
            lg    = w1;
            eaddr = taddr;
          end
        end else begin
          hs0 = 0; hs1 = 0;
          chk("busy_ready0", req0_ready, 0);
          chk("busy_ready1", req1_ready, 0);
          if (ph == 1) begin
            chk("p1_cfg_write", cfg_write, twr && !terr);
            chk("p1_cfg_address", cfg_address, taddr);
            if (twr) chk("p1_cfg_data_in", cfg_data_in, twd);
            chk("p1_rsp0_valid", rsp0_valid, 0);
            chk("p1_rsp1_valid", rsp1_valid, 0);
          end else if (ph == 2 && !twr) begin
            chk("p2_cfg_write", cfg_write, 0);
            chk("p2_cfg_address", cfg_address, taddr);
            chk("p2_rsp0_valid", rsp0_valid, 0);
            chk("p2_rsp1_valid", rsp1_valid, 0);
          end else begin
            chk("rsp_cfg_write", cfg_write, 0);
            chk("rsp0_valid", rsp0_valid, !twho);
            chk("rsp1_valid", rsp1_valid, twho);
            chk("rsp0_err", rsp0_err, !twho && terr);
            chk("rsp1_err", rsp1_err, twho && terr);
            chk("rsp_rdata", rsp_rdata, trd);
            erd = trd;
          end
        end
      end
    end
  end

  task automatic set_req(input bit who, input bit v, input bit wr, input logic [2:0] a, input logic [15:0] d);
    if (who) begin r1v = v; r1w = wr; r1a = a; r1d = d; end
    else begin r0v = v; r0w = wr; r0a = a; r0d = d; end
  endtask

  task automatic do_req(input bit who, input bit wr, input logic [2:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd, output logic er);
    bit ok, got;
    ok = 0; got = 0; lat = 0; rd = 'x; er = 'x;
    @(negedge clk);
    set_req(who, 1, wr, a, d);
    for (int i = 0; i < 30 && !ok; i++) begin
      #2;
      if (who ? hs1 : hs0) ok = 1;
      else @(negedge clk);
    end
    chk("handshake_seen", ok, 1);
    for (int i = 0; i < 10 && ok && !got; i++) begin
      @(negedge clk);
      if (i == 0) set_req(who, 0, wr, a, d);
      lat++;
      #2;
      if (who ? rsp1_valid : rsp0_valid) begin
        got = 1; rd = rsp_rdata; er = who ? rsp1_err : rsp0_err;
      end
    end
    if (!ok) set_req(who, 0, wr, a, d);
    chk("response_seen", got, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic gen(input bit who, input bit took);
    logic v;
    v = who ? r1v : r0v;
    if (took || !v)
      set_req(who, $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, 3'($urandom), 16'($urandom));
    else if ($urandom_range(7, 0) == 0)
      set_req(who, 0, who ? r1w : r0w, who ? r1a : r0a, who ? r1d : r0d);
  endtask

  int lat, n0, n1, rc, nh0, nr0, nr1;
  logic [15:0] rd;
  logic er;
  bit p0, p1;
  int order[$];

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;

    // Write then read back across requesters.
    do_req(0, 1, 3, 16'h00A5, lat, rd, er);
    chk("wr_latency", lat, 2);
    chk("wr_echo", rd, 16'h00A5);
    chk("wr_err", er, 0);
    do_req(1, 0, 3, 16'h0000, lat, rd, er);
    chk("rd_latency", lat, 3);
    chk("rd_data", rd, 16'h00A5);

    // Requester 1 blocked on locked address 0.
    do_req(1, 1, 0, 16'hFFFF, lat, rd, er);
    chk("lock_err", er, 1);
    chk("lock_echo", rd, 16'hFFFF);
    do_req(0, 0, 0, 16'h0000, lat, rd, er);
    chk("lock_readback", rd, 16'h0000);
    chk("lock_rd_err", er, 0);

    // Reset while the write strobe is high.
    do_req(0, 1, 2, 16'h1111, lat, rd, er);
    @(negedge clk);
    set_req(0, 1, 1, 2, 16'h2222);
    #2;
    chk("mid_rst_hs", hs0, 1);
    @(negedge clk);
    set_req(0, 0, 1, 2, 16'h2222);
    #2;
    chk("mid_rst_wr_before", cfg_write, 1);
    reset = 1;
    #1;
    chk("mid_rst_wr_drop", cfg_write, 0);
    chk("mid_rst_rsp0", rsp0_valid, 0);
    repeat (3) @(negedge clk);
    reset = 0;
    #2;
    chk("mid_rst_reg_kept", cr_mem[2], 16'h1111);
    do_req(0, 0, 2, 16'h0000, lat, rd, er);
    chk("mid_rst_readback", rd, 16'h1111);
    chk("mid_rst_rd_latency", lat, 3);

    // Both requesters streaming writes from reset.
    pulse_reset();
    @(negedge clk);
    n0 = 4; n1 = 4; rc = 0; p0 = 0; p1 = 0;
    set_req(0, 1, 1, 3'($urandom), 16'($urandom));
    set_req(1, 1, 1, 3'($urandom), 16'($urandom));
    for (int i = 0; i < 80 && rc < 8; i++) begin
      #2;
      p0 = hs0; p1 = hs1;
      if (hs0) order.push_back(0);
      if (hs1) order.push_back(1);
      if (rsp0_valid) rc++;
      if (rsp1_valid) rc++;
      @(negedge clk);
      if (p0) begin n0--; set_req(0, n0 > 0, 1, 3'($urandom), 16'($urandom)); end
      if (p1) begin n1--; set_req(1, n1 > 0, 1, 3'($urandom), 16'($urandom)); end
    end
    chk("rr_grants", order.size(), 8);
    foreach (order[i]) chk("rr_order", order[i], i % 2);
    chk("rr_responses", rc, 8);

    // Requester 0 raises and drops valid while requester 1 is served.
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    set_req(1, 1, 0, 5, 16'h0000);
    #2;
    chk("drop_hs1", hs1, 1);
    @(negedge clk);
    set_req(1, 0, 0, 5, 16'h0000);
    set_req(0, 1, 1, 4, 16'hBEEF);
    nh0 = 0; nr0 = 0; nr1 = 0;
    #2;
    nh0 += int'(hs0);
    @(negedge clk);
    set_req(0, 0, 1, 4, 16'hBEEF);
    repeat (6) begin
      #2;
      nh0 += int'(hs0); nr0 += int'(rsp0_valid); nr1 += int'(rsp1_valid);
      @(negedge clk);
    end
    chk("drop_no_hs0", nh0, 0);
    chk("drop_no_rsp0", nr0, 0);
    chk("drop_one_rsp1", nr1, 1);

    // Random traffic.
    p0 = 0; p1 = 0;
    for (int i = 0; i < 600; i++) begin
      gen(0, p0);
      gen(1, p1);
      #2;
      p0 = hs0; p1 = hs1;
      @(negedge clk);
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_arbiter.md
# config_arbiter

Two-port arbiter and sequencer for the 8-entry, 16-bit `config_reg` bank. It shares the single `config_reg` write/address/data port between two requesters: requester 0 is the host bus bridge and requester 1 is the calibration engine. Requesters are granted in round-robin order. Each granted request is sequenced as a one-cycle register write, or as an address-then-capture register read, and every request ends with a one-cycle response pulse. An address lock mask write-protects selected registers against requester 1.

## Interface
- `DATA_W`, 16, data width; matches `config_reg`.
- `ADDR_W`, 3, address width; 8 registers.
- `LOCK_MASK`, 8'b0000_0001, bit i = 1 makes address i read-only for requester 1.

Ports:
- `clk`  in  1  single clock for the block; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request pending.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_write` / `req1_write`  in  1  1 = write, 0 = read.
- `req0_addr` / `req1_addr`  in  ADDR_W  target register.
- `req0_wdata` / `req1_wdata`  in  DATA_W  write data.
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle completion pulse.
- `rsp0_err` / `rsp1_err`  out  1  locked-write rejection; valid with `rspN_valid`.
- `rsp_rdata`  out  DATA_W  read data, or echo of the write data; valid with `rspN_valid`.
- `cfg_write`  out  1  drives `config_reg.write`.
- `cfg_address`  out  ADDR_W  drives `config_reg.address`.
- `cfg_data_in`  out  DATA_W  drives `config_reg.data_in`.
- `cfg_data_out`  in  DATA_W  from `config_reg.data_out`.

## Operation
- `config_reg` contract:
  - A write commits `data_in` to `address` on the rising edge where `write` = 1.
  - `data_out` is registered: it shows the register at `address` one cycle after `address` is presented.
- The FSM has five states: IDLE, WRITE, READ, CAPT, RESP.
- IDLE:
  - If any `reqN_valid` is high, pick a winner and assert its `reqN_ready` combinationally in the same cycle.
  - On the valid && ready handshake, latch the op, addr, wdata and winner index.
  - Next state is WRITE for a write and READ for a read.
- Winner selection (round-robin):
  - If both requesters are valid, the one that was not granted last wins.
  - If only one is valid, it wins.
  - `last_grant` updates at the handshake.
- WRITE:
  - Drive `cfg_address`/`cfg_data_in` from the latch.
  - `cfg_write` = 1 for exactly one cycle, unless the winner is 1 and `LOCK_MASK[addr]` = 1. In that case `cfg_write` stays 0 and the error flag is set.
  - Next state is RESP.
- READ: drive `cfg_address`, `cfg_write` = 0. Next state is CAPT.
- CAPT:
  - Hold `cfg_address`.
  - Capture `cfg_data_out` into `rsp_rdata`.
  - Next state is RESP.
- RESP:
  - `rspN_valid` = 1 for the winner only, with `rspN_err` as flagged.
  - `rsp_rdata` = captured read data, or the latched wdata for writes.
  - Next state is IDLE.
- Reads of locked addresses are always permitted. Requester 0 is never locked.
- Requester rules:
  - A requester may drop `valid` before `ready` with no effect.
  - Request fields must stay stable while valid && !ready.
  - Only one request is in flight; `ready` is 0 for both requesters outside IDLE.

## Timing
- Reset values:
  - State = IDLE, `last_grant` = 1, so requester 0 wins first.
  - All outputs = 0: `cfg_write`, `cfg_address`, `cfg_data_in`, `rsp_rdata`, both `ready`, both `rsp_valid`, both `rsp_err`.
- Write latency, with the handshake at cycle T:
  - `cfg_write` high in T+1; the register updates at the end of T+1.
  - `rspN_valid` in T+2.
- Read latency:
  - `cfg_address` is valid from T+1.
  - `cfg_data_out` is sampled in T+2.
  - `rspN_valid` with data in T+3.
- Throughput: the next handshake is earliest at T+3 for a write and T+4 for a read. One IDLE cycle always separates operations.
- While IDLE:
  - `cfg_write` = 0 and `cfg_data_in` = 0.
  - `cfg_address` holds its last value.
  - `rsp_rdata` holds its last value.
- Reset asserted mid-operation:
  - Immediate return to the reset values; no response is issued.
  - A write in WRITE state at the moment of reset must not commit, because `cfg_write` drops asynchronously.
- `rsp0_valid` and `rsp1_valid` are never high together.

## Test plan
- Reset, then `req0` writes addr 3 = 16'h00A5 at T: `cfg_write` pulses in T+1, `rsp0_valid` in T+2 with `rsp_rdata` = 16'h00A5 and `rsp0_err` = 0.
- `req1` reads addr 3 after the write above: `rsp1_valid` 3 cycles after the handshake, `rsp_rdata` = 16'h00A5.
- Both requesters valid continuously with 4 writes each: grants alternate 0,1,0,1…, starting with 0 after reset; no `cfg_write` overlap; 8 responses total.
- `req1` writes locked addr 0 with 16'hFFFF: `cfg_write` stays 0, `rsp1_err` = 1, and a subsequent `req0` read of addr 0 returns the reset/previous value.
- Reset pulsed during WRITE state: `cfg_write` falls immediately, no `rsp` pulse, the register is unchanged, and the next request after release is accepted normally.
- `req0_valid` raised then dropped while the FSM is busy serving `req1`: no handshake for `req0` and no spurious response for it.
